// File: rtl/dmi_tap_pkg.sv
// ---------------------------------------------------------------------------
// dmi_tap_pkg
// Shared definitions for the DMI JTAG TAP: the 16 IEEE 1149.1 controller
// states, the state the controller resets into, and small decode helpers
// used by both the FSM and the register/TDO logic.
// ---------------------------------------------------------------------------
package dmi_tap_pkg;

  // Encoding is arbitrary but fixed so that waveforms and hierarchical
  // peeks read the same across builds.
  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'ha,
    SHIFT_IR         = 4'hb,
    EXIT1_IR         = 4'hc,
    PAUSE_IR         = 4'hd,
    EXIT2_IR         = 4'he,
    UPDATE_IR        = 4'hf
  } tap_state_e;

  localparam tap_state_e TAP_RESET_STATE = TEST_LOGIC_RESET;
  localparam int unsigned TAP_NUM_STATES = 16;
  localparam int unsigned IDCODE_W       = 32;

  // TDO is driven only while one of the two shift states is active.
  function automatic logic is_shift_state(input tap_state_e s);
    return (s == SHIFT_IR) || (s == SHIFT_DR);
  endfunction

endpackage

// File: rtl/dmi_tap_fsm.sv
// ---------------------------------------------------------------------------
// dmi_tap_fsm
// IEEE 1149.1 TAP controller state machine. Advances on rising tck_i.
// Ports:
//   tck_i  - TAP clock
//   rst_i  - synchronous active-high reset, forces test_logic_reset
//   tms_i  - test mode select
//   state  - current controller state
// ---------------------------------------------------------------------------
module dmi_tap_fsm
  import dmi_tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state
);

  tap_state_e state_q = TAP_RESET_STATE;
  tap_state_e state_d;

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state_q <= TAP_RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_d = tms_i ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_d = TAP_RESET_STATE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/dmi_jtag_tap.sv
// ---------------------------------------------------------------------------
// dmi_jtag_tap
// JTAG TAP front end for a RISC-V debug transport: instruction register,
// internal IDCODE and BYPASS data registers, external DR channel selection
// and falling-edge TDO generation.
// Ports:
//   tck_i        - TAP clock, the only clock
//   rst_i        - synchronous active-high reset (both clock edges)
//   tms_i/tdi_i  - JTAG mode select / serial data in
//   tdo_o        - serial data out, registered on falling tck_i
//   tdo_oe_o     - tdo_o valid, high while in shift_ir / shift_dr
//   update_o     - state is update_dr
//   capture_o    - state is capture_dr
//   shift_o      - state is shift_dr
//   dr_select_o  - one-hot (or zero) external channel select
//   dr_tdo_i     - serial out of each external channel
//   dr_clear_o   - state is test_logic_reset
// ---------------------------------------------------------------------------
module dmi_jtag_tap
  import dmi_tap_pkg::*;
#(
  parameter int unsigned          IR_WIDTH        = 10,
  parameter int unsigned          NUM_DR          = 2,
  parameter logic [IR_WIDTH-1:0]  DR_IR [NUM_DR]  = '{10'h00c, 10'h00e},
  parameter logic [IR_WIDTH-1:0]  IDCODE_IR       = 10'h001,
  parameter logic [IDCODE_W-1:0]  IDCODE          = 32'h0000_0001
) (
  input  logic              tck_i,
  input  logic              rst_i,
  input  logic              tms_i,
  input  logic              tdi_i,
  output logic              tdo_o,
  output logic              tdo_oe_o,
  output logic              update_o,
  output logic              capture_o,
  output logic              shift_o,
  output logic [NUM_DR-1:0] dr_select_o,
  input  logic [NUM_DR-1:0] dr_tdo_i,
  output logic              dr_clear_o
);

  // Bad parameterisations are rejected at elaboration. IDCODE bit 0 must be
  // 1 so a host can tell IDCODE apart from BYPASS after reset.
  if (IR_WIDTH < 2) begin : g_bad_ir_width
    $error("dmi_jtag_tap: IR_WIDTH must be at least 2");
  end
  if (NUM_DR < 1) begin : g_bad_num_dr
    $error("dmi_jtag_tap: NUM_DR must be at least 1");
  end
  if (IDCODE[0] != 1'b1) begin : g_bad_idcode
    $error("dmi_jtag_tap: IDCODE bit 0 must be 1");
  end

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e state;

  dmi_tap_fsm u_fsm (
    .tck_i (tck_i),
    .rst_i (rst_i),
    .tms_i (tms_i),
    .state (state)
  );

  // Declaration initialisers give the same power-up contents as reset.
  logic [IR_WIDTH-1:0] ir_reg     = IDCODE_IR;
  logic [IR_WIDTH-1:0] ir_shift   = '0;
  logic [IDCODE_W-1:0] idcode_reg = '0;
  logic                bypass_reg = 1'b0;
  logic                tdo_q      = 1'b0;
  logic                tdo_oe_q   = 1'b0;

  logic                idcode_sel;
  logic                bypass_sel;
  logic                ext_sel;
  logic [NUM_DR-1:0]   dr_select;
  logic                tdo_d;

  // State decodes
  assign update_o   = (state == UPDATE_DR);
  assign capture_o  = (state == CAPTURE_DR);
  assign shift_o    = (state == SHIFT_DR);
  assign dr_clear_o = (state == TEST_LOGIC_RESET);

  // Instruction register. ir_reg only moves in update_ir or
  // test_logic_reset, which keeps dr_select stable through any DR scan.
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      ir_reg   <= IDCODE_IR;
      ir_shift <= '0;
    end else begin
      unique case (state)
        TEST_LOGIC_RESET: ir_reg   <= IDCODE_IR;
        CAPTURE_IR:       ir_shift <= IR_CAPTURE;
        SHIFT_IR:         ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
        UPDATE_IR:        ir_reg   <= ir_shift;
        default:          ;
      endcase
    end
  end

  // DR selection. IDCODE_IR takes precedence over any matching external
  // code; among duplicate external codes the lowest channel wins.
  assign idcode_sel = (ir_reg == IDCODE_IR);

  always_comb begin
    logic found;
    found     = 1'b0;
    dr_select = '0;
    if (!idcode_sel) begin
      for (int unsigned k = 0; k < NUM_DR; k++) begin
        if (!found && (ir_reg == DR_IR[k])) begin
          dr_select[k] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  assign ext_sel     = |dr_select;
  assign bypass_sel  = !idcode_sel && !ext_sel;
  assign dr_select_o = dr_select;

  // Internal data registers
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      idcode_reg <= '0;
      bypass_reg <= 1'b0;
    end else if (idcode_sel) begin
      if (state == CAPTURE_DR) begin
        idcode_reg <= IDCODE;
      end else if (state == SHIFT_DR) begin
        idcode_reg <= {tdi_i, idcode_reg[IDCODE_W-1:1]};
      end
    end else if (bypass_sel) begin
      if (state == CAPTURE_DR) begin
        bypass_reg <= 1'b0;
      end else if (state == SHIFT_DR) begin
        bypass_reg <= tdi_i;
      end
    end
  end

  // TDO source mux. Because the capture happened on the preceding rising
  // edge, bit 0 of the captured DR is already present half a cycle later.
  always_comb begin
    tdo_d = 1'b0;
    unique case (state)
      SHIFT_IR: tdo_d = ir_shift[0];
      SHIFT_DR: begin
        if (ext_sel) begin
          tdo_d = |(dr_select & dr_tdo_i);
        end else if (idcode_sel) begin
          tdo_d = idcode_reg[0];
        end else begin
          tdo_d = bypass_reg;
        end
      end
      default: tdo_d = 1'b0;
    endcase
  end

  // Falling-edge output stage
  always_ff @(negedge tck_i) begin
    if (rst_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= is_shift_state(state);
    end
  end

  assign tdo_o    = tdo_q;
  assign tdo_oe_o = tdo_oe_q;

endmodule

// File: doc/dmi_jtag_tap.md
DMI_JTAG_TAP -- requirements
Module: dmi_jtag_tap

Interface
REQ-001 SHALL provide parameter IR_WIDTH, default 10, instruction register length (min 2).
REQ-002 SHALL provide parameter NUM_DR, default 2, number of external data-register channels (min 1).
REQ-003 SHALL provide parameter DR_IR[NUM_DR], default {10'h00c, 10'h00e}, the instruction code selecting each channel (index 0 = dtmcs, 1 = dmi).
REQ-004 SHALL provide parameter IDCODE_IR, default 10'h001, the instruction selecting the internal IDCODE register.
REQ-005 SHALL provide parameter IDCODE, default 32'h0000_0001, the IDCODE value; bit 0 SHALL be 1 (elaboration check).
REQ-006 Ports SHALL be:
- tck_i  in  1  TAP clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- tms_i  in  1  test mode select.
- tdi_i  in  1  test data in.
- tdo_o  out  1  test data out, falling-edge registered.
- tdo_oe_o  out  1  tdo_o valid (shift state).
- update_o  out  1  FSM in update_dr.
- capture_o  out  1  FSM in capture_dr.
- shift_o  out  1  FSM in shift_dr.
- dr_select_o  out  NUM_DR  one-hot (or zero) external channel select.
- dr_tdo_i  in  NUM_DR  serial out of each external channel.
- dr_clear_o  out  1  FSM in test_logic_reset.

Function
REQ-007 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on rising tck_i per standard TMS transitions; pause_ir with TMS=0 SHALL remain in pause_ir.
REQ-008 Five consecutive rising edges with tms_i=1 SHALL reach test_logic_reset from any state.
REQ-009 update_o, capture_o, shift_o, dr_clear_o SHALL be combinational decodes of the current state.
REQ-010 In test_logic_reset, ir_reg SHALL load IDCODE_IR on each rising edge.
REQ-011 In capture_ir, ir_shift SHALL load {zeros, 2'b01}; in shift_ir, ir_shift SHALL shift right with tdi_i entering bit IR_WIDTH-1; in update_ir, ir_reg SHALL load ir_shift.
REQ-012 dr_select_o[k] SHALL be 1 iff ir_reg == DR_IR[k] and ir_reg != IDCODE_IR; on duplicate DR_IR codes, the lowest index SHALL win.
REQ-013 ir_reg == IDCODE_IR SHALL select the internal 32-bit IDCODE DR: capture_dr loads IDCODE; shift_dr shifts right, tdi_i into bit 31.
REQ-014 Any other ir_reg value (including all-ones) SHALL select the internal 1-bit BYPASS DR: capture_dr loads 0; shift_dr loads tdi_i.
REQ-015 On falling tck_i: in shift_ir, tdo_o = ir_shift[0]; in shift_dr, tdo_o = the selected source (dr_tdo_i[k], IDCODE bit 0, or bypass bit); otherwise tdo_o = 0.
REQ-016 tdo_oe_o SHALL be registered on falling tck_i, 1 iff the state is shift_ir or shift_dr.
REQ-017 Capture-to-first-bit latency SHALL be one half tck period: data-register bit 0 appears on tdo_o at the falling edge of the first shift_dr cycle.
REQ-018 ir_reg SHALL change only in update_ir or test_logic_reset; dr_select_o SHALL be stable throughout a DR scan.

Reset
REQ-019 rst_i high at a rising tck_i edge SHALL force state to test_logic_reset, ir_reg to IDCODE_IR, ir_shift to 0, and the IDCODE/BYPASS registers to 0.
REQ-020 rst_i high at a falling tck_i edge SHALL force tdo_o=0, tdo_oe_o=0.
REQ-021 Reset asserted mid-scan SHALL discard the partial shift with no update.
REQ-022 Power-up register initial values SHALL equal the reset values.

Structure
REQ-023 Package dmi_tap_pkg SHALL hold the TAP state enum and the state-name constants.
REQ-024 The FSM SHALL be a sub-module dmi_tap_fsm (tck_i, rst_i, tms_i -> state); register, decode, and TDO logic SHALL live in dmi_jtag_tap.

Verification
REQ-025 rst_i pulse, then TMS=0 -> run_test_idle; DR scan of 32 bits -> tdo_o streams 32'h0000_0001 LSB first, tdo_oe_o=1 only during shift.
REQ-026 IR scan of 10'h00e -> ir_shift captured 10'b0000000001 out on tdo_o; after update_ir dr_select_o=2'b10; DR shift of 41 bits -> tdo_o mirrors dr_tdo_i[1] each falling edge.
REQ-027 IR=10'h3ff, shift 8 bits 8'hA5 -> tdo_o = 0 then tdi delayed one cycle (bypass).
REQ-028 From shift_dr, 5 rising edges with TMS=1 -> test_logic_reset, dr_clear_o=1, ir_reg=IDCODE_IR.
REQ-029 Enter pause_ir, hold TMS=0 for 4 cycles -> state remains pause_ir; exit2_ir -> update_ir loads shifted value.
REQ-030 rst_i asserted during shift_ir after 5 bits -> next state test_logic_reset, ir_reg unchanged from IDCODE_IR, tdo_oe_o=0.
